pmem_scheduler: RTL and testbench

- Registered three-way scheduler for the single physical-memory port. Requesters: instruction cache (read only), data cache (read/write) and next-line prefetcher (read only).
- Grants one 256-bit line transaction at a time.
- Latches the granted request's address, data and command into registers that drive pmem.
- Fixed priority dcache > icache > prefetch, with an icache anti-starvation override.
- Sits between the cache/prefetch level and physical memory.

---
 rtl/pmem_scheduler.sv | 140 ++++++++++++++
 tb/tb_pmem_scheduler.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_scheduler.sv
// pmem_scheduler: registered three-way arbiter for the single physical-memory
// port. One 256-bit line transaction is outstanding at a time; the winner's
// address/command/data are captured into registers that drive pmem directly.
// Priority is dcache > icache > prefetch, with an icache anti-starvation
// override after STARVE_LIMIT dcache grants taken while icache was waiting.
module pmem_scheduler #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  icache_address,
    input  logic         icache_read,
    output logic         icache_resp,
    output logic [255:0] icache_rdata,
    input  logic [31:0]  dcache_address,
    input  logic         dcache_read,
    input  logic         dcache_write,
    input  logic [255:0] dcache_wdata,
    output logic         dcache_resp,
    output logic [255:0] dcache_rdata,
    input  logic [31:0]  pf_address,
    input  logic         pf_read,
    output logic         pf_resp,
    output logic [255:0] pf_rdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        BUSY_I  = 3'd1,
        BUSY_D  = 3'd2,
        BUSY_P  = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t         state_reg, state_next;
    logic [3:0]     starve_cnt_reg, starve_cnt_next;
    logic [31:0]    addr_reg, addr_next;
    logic           read_reg, read_next;
    logic           write_reg, write_next;
    logic [255:0]   wdata_reg, wdata_next;

    // State, starvation counter and the captured pmem command registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
            addr_reg       <= 32'd0;
            read_reg       <= 1'b0;
            write_reg      <= 1'b0;
            wdata_reg      <= 256'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            addr_reg       <= addr_next;
            read_reg       <= read_next;
            write_reg      <= write_next;
            wdata_reg      <= wdata_next;
        end
    end

    // Arbitration in IDLE, completion detection in BUSY_x, one-cycle RELEASE.
    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        addr_next       = addr_reg;
        read_next       = read_reg;
        write_next      = write_reg;
        wdata_next      = wdata_reg;
        case (state_reg)
            IDLE: begin
                if ((starve_cnt_reg == LIMIT) && icache_read) begin
                    state_next      = BUSY_I;
                    addr_next       = icache_address;
                    read_next       = 1'b1;
                    write_next      = 1'b0;
                    wdata_next      = 256'd0;
                    starve_cnt_next = 4'd0;
                end else if (dcache_read || dcache_write) begin
                    state_next = BUSY_D;
                    addr_next  = dcache_address;
                    read_next  = dcache_read;
                    write_next = dcache_write;
                    wdata_next = dcache_wdata;
                    // Count only grants that actually made icache wait.
                    if (icache_read && (starve_cnt_reg != LIMIT))
                        starve_cnt_next = starve_cnt_reg + 4'd1;
                end else if (icache_read) begin
                    state_next      = BUSY_I;
                    addr_next       = icache_address;
                    read_next       = 1'b1;
                    write_next      = 1'b0;
                    wdata_next      = 256'd0;
                    starve_cnt_next = 4'd0;
                end else if (pf_read) begin
                    state_next = BUSY_P;
                    addr_next  = pf_address;
                    read_next  = 1'b1;
                    write_next = 1'b0;
                    wdata_next = 256'd0;
                end
            end
            BUSY_I, BUSY_D, BUSY_P: begin
                if (pmem_resp) begin
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    state_next = RELEASE;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Responses are steered combinationally to the current owner only, so a
    // stray pmem_resp outside a BUSY state reaches nobody.
    assign icache_resp  = (state_reg == BUSY_I) && pmem_resp;
    assign dcache_resp  = (state_reg == BUSY_D) && pmem_resp;
    assign pf_resp      = (state_reg == BUSY_P) && pmem_resp;
    assign icache_rdata = icache_resp ? pmem_rdata : 256'd0;
    assign dcache_rdata = dcache_resp ? pmem_rdata : 256'd0;
    assign pf_rdata     = pf_resp     ? pmem_rdata : 256'd0;

    assign pmem_address = addr_reg;
    assign pmem_read    = read_reg;
    assign pmem_write   = write_reg;
    assign pmem_wdata   = wdata_reg;

    // dcache must never issue a read and a write in the same cycle.
    a_dcache_rw_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(dcache_read && dcache_write));

endmodule

// File: tb/tb_pmem_scheduler.sv
// Directed testbench for pmem_scheduler: each scenario task drives its own
// stimulus and checks hand-computed values, one line per transaction.
module tb_pmem_scheduler;

    logic         clk;
    logic         rst;
    logic [31:0]  icache_address;
    logic         icache_read;
    logic         icache_resp;
    logic [255:0] icache_rdata;
    logic [31:0]  dcache_address;
    logic         dcache_read;
    logic         dcache_write;
    logic [255:0] dcache_wdata;
    logic         dcache_resp;
    logic [255:0] dcache_rdata;
    logic [31:0]  pf_address;
    logic         pf_read;
    logic         pf_resp;
    logic [255:0] pf_rdata;
    logic         pmem_resp;
    logic [255:0] pmem_rdata;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;

    int errors;
    int checks;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_W  = {16{16'h1234}};

    pmem_scheduler #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .icache_address(icache_address), .icache_read(icache_read),
        .icache_resp(icache_resp), .icache_rdata(icache_rdata),
        .dcache_address(dcache_address), .dcache_read(dcache_read),
        .dcache_write(dcache_write), .dcache_wdata(dcache_wdata),
        .dcache_resp(dcache_resp), .dcache_rdata(dcache_rdata),
        .pf_address(pf_address), .pf_read(pf_read),
        .pf_resp(pf_resp), .pf_rdata(pf_rdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .pmem_address(pmem_address), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_wdata(pmem_wdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        icache_address = 32'd0; icache_read = 1'b0;
        dcache_address = 32'd0; dcache_read = 1'b0; dcache_write = 1'b0;
        dcache_wdata = 256'd0;
        pf_address = 32'd0; pf_read = 1'b0;
        pmem_resp = 1'b0; pmem_rdata = 256'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00 || pmem_address !== 32'd0 || pmem_wdata !== 256'd0) begin
            errors++;
            $display("FAIL reset_pmem: rd=%0b wr=%0b addr=%h wdata=%h required all zero",
                     pmem_read, pmem_write, pmem_address, pmem_wdata);
        end
        checks++;
        if ({icache_resp, dcache_resp, pf_resp} !== 3'b000 ||
            (icache_rdata | dcache_rdata | pf_rdata) !== 256'd0) begin
            errors++;
            $display("FAIL reset_resp: resp=%b required 000, rdata not all zero or as required",
                     {icache_resp, dcache_resp, pf_resp});
        end
        @(negedge clk);
        rst = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_single_icache();
        do_reset();
        @(negedge clk);
        icache_address = 32'h0000_0040;
        icache_read    = 1'b1;
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL single_cycle0: pmem_read=%0b required 0", pmem_read);
        end
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h40 || pmem_wdata !== 256'd0) begin
            errors++;
            $display("FAIL single_grant: rd=%0b wr=%0b addr=%h required rd=1 wr=0 addr=00000040 wdata=0",
                     pmem_read, pmem_write, pmem_address);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (pmem_read !== 1'b1 || icache_resp !== 1'b0) begin
                errors++;
                $display("FAIL single_wait: rd=%0b resp=%0b required rd=1 resp=0", pmem_read, icache_resp);
            end
        end
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = PAT_A5;
        #1;
        checks++;
        if (icache_resp !== 1'b1 || icache_rdata !== PAT_A5) begin
            errors++;
            $display("FAIL single_resp: resp=%0b rdata=%h required 1 and a5 pattern", icache_resp, icache_rdata);
        end
        checks++;
        if (dcache_resp !== 1'b0 || pf_resp !== 1'b0 || dcache_rdata !== 256'd0 || pf_rdata !== 256'd0) begin
            errors++;
            $display("FAIL single_others: dresp=%0b presp=%0b required 0 with zero rdata", dcache_resp, pf_resp);
        end
        @(negedge clk);
        pmem_resp   = 1'b0;
        pmem_rdata  = 256'd0;
        icache_read = 1'b0;
        #1;
        checks++;
        if (icache_resp !== 1'b0 || pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL single_after: resp=%0b rd=%0b required 0 0", icache_resp, pmem_read);
        end
        $display("txn single icache read addr=00000040");
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        icache_address = 32'h80;  icache_read  = 1'b1;
        dcache_address = 32'h100; dcache_write = 1'b1; dcache_wdata = PAT_W;
        pf_address     = 32'h180; pf_read      = 1'b1;
        // D first: write with the dcache data.
        @(negedge clk);
        checks++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h100 || pmem_wdata !== PAT_W) begin
            errors++;
            $display("FAIL simul_d_grant: rd=%0b wr=%0b addr=%h wdata=%h required wr=1 addr=00000100 1234 pattern",
                     pmem_read, pmem_write, pmem_address, pmem_wdata);
        end
        pmem_resp = 1'b1; pmem_rdata = 256'h77;
        #1;
        checks++;
        if ({icache_resp, dcache_resp, pf_resp} !== 3'b010) begin
            errors++;
            $display("FAIL simul_d_resp: i/d/p resp=%b required 010", {icache_resp, dcache_resp, pf_resp});
        end
        @(negedge clk);
        pmem_resp = 1'b0; dcache_write = 1'b0;
        #1;
        checks++;
        if (pmem_write !== 1'b0 || {icache_resp, dcache_resp, pf_resp} !== 3'b000) begin
            errors++;
            $display("FAIL simul_d_release: wr=%0b resp=%b required 0 000", pmem_write, {icache_resp, dcache_resp, pf_resp});
        end
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL simul_release_gap: rd=%0b required 0 (release cycle)", pmem_read);
        end
        // I second.
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h80 || pmem_wdata !== 256'd0) begin
            errors++;
            $display("FAIL simul_i_grant: rd=%0b addr=%h required 1 00000080 wdata 0", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1; pmem_rdata = 256'h99;
        #1;
        checks++;
        if ({icache_resp, dcache_resp, pf_resp} !== 3'b100 || icache_rdata !== 256'h99) begin
            errors++;
            $display("FAIL simul_i_resp: resp=%b rdata=%h required 100 rdata 99", {icache_resp, dcache_resp, pf_resp}, icache_rdata);
        end
        @(negedge clk);
        pmem_resp = 1'b0; icache_read = 1'b0;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL simul_release_gap2: rd=%0b required 0", pmem_read);
        end
        // P last.
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h180) begin
            errors++;
            $display("FAIL simul_p_grant: rd=%0b addr=%h required 1 00000180", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1; pmem_rdata = 256'h55;
        #1;
        checks++;
        if ({icache_resp, dcache_resp, pf_resp} !== 3'b001 || pf_rdata !== 256'h55) begin
            errors++;
            $display("FAIL simul_p_resp: resp=%b rdata=%h required 001 rdata 55", {icache_resp, dcache_resp, pf_resp}, pf_rdata);
        end
        @(negedge clk);
        pmem_resp = 1'b0; pf_read = 1'b0;
        $display("txn simultaneous D,I,P done");
    endtask

    task automatic test_starvation();
        logic [5:0] exp_d;
        logic       found;
        exp_d = 6'b101111;  // bit k = 1 means grant k goes to dcache
        do_reset();
        @(negedge clk);
        dcache_address = 32'h400; dcache_read = 1'b1;
        icache_address = 32'h500; icache_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                @(negedge clk);
                if (pmem_read === 1'b1) found = 1'b1;
            end
            checks++;
            if (!found) begin
                errors++;
                $display("FAIL starve_timeout: grant %0d never seen, pmem_read=%0b required 1", k, pmem_read);
            end
            checks++;
            if (pmem_address !== (exp_d[k] ? 32'h400 : 32'h500)) begin
                errors++;
                $display("FAIL starve_order: grant %0d addr=%h required %h", k, pmem_address,
                         exp_d[k] ? 32'h400 : 32'h500);
            end
            pmem_resp = 1'b1; pmem_rdata = 256'(k + 1);
            #1;
            checks++;
            if (dcache_resp !== exp_d[k] || icache_resp !== !exp_d[k] || pf_resp !== 1'b0) begin
                errors++;
                $display("FAIL starve_resp: grant %0d i/d/p=%b required %b", k,
                         {icache_resp, dcache_resp, pf_resp}, {!exp_d[k], exp_d[k], 1'b0});
            end
            $display("txn starve grant %0d addr=%h", k, pmem_address);
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        dcache_read = 1'b0; icache_read = 1'b0;
    endtask

    task automatic test_input_change();
        do_reset();
        @(negedge clk);
        dcache_address = 32'h200; dcache_read = 1'b1;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h200) begin
            errors++;
            $display("FAIL change_grant: rd=%0b addr=%h required 1 00000200", pmem_read, pmem_address);
        end
        dcache_address = 32'h300;
        dcache_wdata   = PAT_A5;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (pmem_address !== 32'h200 || pmem_wdata !== 256'd0) begin
                errors++;
                $display("FAIL change_hold: addr=%h required 00000200 with wdata 0", pmem_address);
            end
        end
        pmem_resp = 1'b1; pmem_rdata = 256'h3;
        #1;
        checks++;
        if (dcache_resp !== 1'b1 || dcache_rdata !== 256'h3 || pmem_address !== 32'h200) begin
            errors++;
            $display("FAIL change_resp: resp=%0b addr=%h required 1 00000200", dcache_resp, pmem_address);
        end
        @(negedge clk);
        pmem_resp = 1'b0; dcache_read = 1'b0;
        $display("txn input change mid dcache read");
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        @(negedge clk);
        icache_address = 32'h40; icache_read = 1'b1;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_grant: rd=%0b required 1", pmem_read);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (pmem_read !== 1'b0 || pmem_address !== 32'd0) begin
            errors++;
            $display("FAIL rstmid_async: rd=%0b addr=%h required 0 00000000", pmem_read, pmem_address);
        end
        icache_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pmem_resp = 1'b1; pmem_rdata = PAT_A5;
        #1;
        checks++;
        if ({icache_resp, dcache_resp, pf_resp} !== 3'b000 || icache_rdata !== 256'd0) begin
            errors++;
            $display("FAIL rstmid_late_resp: resp=%b required 000 with zero rdata", {icache_resp, dcache_resp, pf_resp});
        end
        @(negedge clk);
        pmem_resp = 1'b0;
        $display("txn reset mid transaction");
    endtask

    task automatic test_idle_noise();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            pmem_resp = 1'b1; pmem_rdata = PAT_W;
            #1;
            checks++;
            if ({icache_resp, dcache_resp, pf_resp} !== 3'b000 ||
                (icache_rdata | dcache_rdata | pf_rdata) !== 256'd0) begin
                errors++;
                $display("FAIL noise_resp: pulse %0d resp=%b required 000 with zero rdata", k,
                         {icache_resp, dcache_resp, pf_resp});
            end
            @(negedge clk);
            pmem_resp = 1'b0;
        end
        // Still in IDLE: a fresh request must be granted with normal latency.
        icache_address = 32'h600; icache_read = 1'b1;
        @(negedge clk);
        checks++;
        if (pmem_read !== 1'b1 || pmem_address !== 32'h600) begin
            errors++;
            $display("FAIL noise_idle: rd=%0b addr=%h required 1 00000600", pmem_read, pmem_address);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if (icache_resp !== 1'b1) begin
            errors++;
            $display("FAIL noise_after_resp: resp=%0b required 1", icache_resp);
        end
        @(negedge clk);
        pmem_resp = 1'b0; icache_read = 1'b0;
        $display("txn idle noise, then icache read addr=00000600");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        clear_inputs();
        #2;
        test_reset();
        test_single_icache();
        test_simultaneous();
        test_starvation();
        test_input_change();
        test_reset_mid_txn();
        test_idle_noise();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
